led_pattern_gen: RTL
====================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The parameter NUM_CH SHALL default to 4 and set the number of bicolour LED channels (range 1..16).
REQ-002 The parameter SLOW_TICKS SHALL default to 31 and set the slow-blink half period in Strobe16ms pulses (about 0.5 s).
REQ-003 The parameter FAST_TICKS SHALL default to 8 and set the fast-blink half period in Strobe16ms pulses (about 128 ms).
REQ-004 The parameter TEST_TICKS SHALL default to 62 and set the duration of each lamp-test phase in Strobe16ms pulses.
REQ-005 Port SlowClock SHALL be an input, 1 bit: the 32,768 Hz clock. This is the block's only clock.
REQ-006 Port Reset SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-007 Port Strobe16ms SHALL be an input, 1 bit: a single-SlowClock pulse every 16 ms.
REQ-008 Port PwrOn SHALL be an input, 1 bit: when 1, channel display is enabled.
REQ-009 Port ChMode SHALL be an input, 3*NUM_CH bits: the per-channel mode; channel n occupies bits [3n+2:3n].
REQ-010 Port FaultIn SHALL be an input, NUM_CH bits: per-channel fault-set, level-sampled each cycle.
REQ-011 Port FaultClr SHALL be an input, NUM_CH bits: per-channel fault-latch clear, one-cycle pulse.
REQ-012 Port LampTest SHALL be an input, 1 bit: a lamp-test request; a rising edge starts the test.
REQ-013 Port LedG_N SHALL be an output, NUM_CH bits: green drive, active-low.
REQ-014 Port LedR_N SHALL be an output, NUM_CH bits: red drive, active-low.
REQ-015 Port FaultLatched SHALL be an output, NUM_CH bits: the current state of the fault latches.
REQ-016 Port TestBusy SHALL be an output, 1 bit: 1 while the lamp test runs.

Function
REQ-017 The timebase SHALL keep a slow counter that counts Strobe16ms pulses from 0 to SLOW_TICKS-1, wraps to 0 on the next pulse and toggles SlowPhase at the wrap; it holds its value between strobes.
REQ-018 The timebase SHALL keep a fast counter and FastPhase that behave the same way with FAST_TICKS; both phases are free-running and shared by all channels.
REQ-019 Mode encodings SHALL map to (G,R) as follows:
- 0: off
- 1: green
- 2: red
- 3: amber (both on)
- 4: green gated by SlowPhase
- 5: red gated by SlowPhase
- 6: green when SlowPhase=1, red when SlowPhase=0
- 7: red gated by FastPhase
REQ-020 FaultLatched[n] SHALL be set on any cycle where FaultIn[n]=1 and cleared by FaultClr[n]=1; when both occur in the same cycle, set wins.
REQ-021 While FaultLatched[n]=1, channel n SHALL show red gated by FastPhase regardless of ChMode.
REQ-022 When PwrOn=0, every channel SHALL be off; fault latches and counters SHALL keep running.
REQ-023 The lamp-test FSM SHALL have the states IDLE, TEST_G and TEST_R:
- IDLE goes to TEST_G on a LampTest rising edge (detected against a registered copy of LampTest).
- TEST_G goes to TEST_R after TEST_TICKS strobes.
- TEST_R goes to IDLE after TEST_TICKS strobes.
REQ-024 LampTest edges that occur while the FSM is not IDLE SHALL be ignored.
REQ-025 During TEST_G all channels SHALL show green only, and during TEST_R all channels SHALL show red only; the lamp test overrides PwrOn, faults and ChMode. TestBusy SHALL be 1 outside IDLE.
REQ-026 Output priority SHALL be, highest first: lamp test, PwrOn=0, fault latch, ChMode.
REQ-027 LedG_N and LedR_N SHALL be registered, with one SlowClock of latency from any input or phase change.
REQ-028 The lamp-test phase counter SHALL be cleared on entry to each test state.

Reset
REQ-029 On Reset=1 the block SHALL asynchronously drive:
- LedG_N and LedR_N to all ones;
- FaultLatched to 0;
- TestBusy to 0;
- all counters and both phases to 0;
- the FSM to IDLE;
- the registered LampTest copy to 0.
REQ-030 Deasserting reset mid-test SHALL leave the block in IDLE; a LampTest input held high SHALL NOT retrigger the test until it goes low and then high again.

Structure
REQ-031 Package led_pkg SHALL hold the mode encodings, the lamp-test FSM state enumeration and the off/green/red/amber LED-state constants.
REQ-032 The slow and fast prescalers SHALL be one instance each of the sub-module led_blink_timebase, parametrised by half-period ticks, with outputs Phase and Wrap.
REQ-033 Per-channel decode SHALL be a generate loop over NUM_CH.

Verification
REQ-034 Reset scenario: assert Reset mid-TEST_R, then release -> all outputs are 1, TestBusy=0 and FaultLatched=0 within the same cycle.
REQ-035 Blink timing scenario: NUM_CH=4, ChMode ch0=4, strobes applied -> LedG_N[0] toggles exactly every 31 strobes; ch1=1 holds LedG_N[1]=0 steadily.
REQ-036 Fault latch scenario:
- FaultIn[2] pulsed for one cycle with ch2 mode=1 -> red toggles every 8 strobes and green is off.
- FaultIn[2] and FaultClr[2] asserted together -> the latch stays set.
- FaultClr alone -> green returns 1 cycle later.
REQ-037 Lamp test scenario: LampTest rising edge with PwrOn=0 -> all green for 62 strobes, all red for 62 strobes, then all off; a second edge during the test is ignored.
REQ-038 Power gating scenario: PwrOn=0 with all modes=3 -> all outputs are 1; set PwrOn=1 -> LedG_N and LedR_N are all 0 one cycle later.
REQ-039 Parameter sweep scenario: NUM_CH=1 and NUM_CH=16 with SLOW_TICKS=2 and FAST_TICKS=1 -> the wrap boundary toggles the phase on the 2nd and 1st strobe respectively.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the bicolour LED pattern generator.
package led_pkg;

  // Per-channel display modes carried on ChMode
  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_GREEN  = 3'd1,
    MODE_RED    = 3'd2,
    MODE_AMBER  = 3'd3,
    MODE_SLOW_G = 3'd4,
    MODE_SLOW_R = 3'd5,
    MODE_ALT    = 3'd6,
    MODE_FAST_R = 3'd7
  } led_mode_e;

  // Lamp-test sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TEST_G = 2'd1,
    TEST_R = 2'd2
  } lt_state_e;

  // Active-high lamp state of one bicolour channel
  typedef struct packed {
    logic g;
    logic r;
  } led_state_t;

  localparam led_state_t LED_OFF   = '{g: 1'b0, r: 1'b0};
  localparam led_state_t LED_GREEN = '{g: 1'b1, r: 1'b0};
  localparam led_state_t LED_RED   = '{g: 1'b0, r: 1'b1};
  localparam led_state_t LED_AMBER = '{g: 1'b1, r: 1'b1};

  // Counter width able to hold 0..ticks-1 (never narrower than one bit)
  function automatic int unsigned cnt_width(input int unsigned ticks);
    return (ticks <= 1) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/led_blink_timebase.sv
// Strobe-driven half-period prescaler: counts strobes 0..TICKS-1 and toggles
// Phase on the strobe that wraps the count. Wrap flags that strobe.
module led_blink_timebase
  import led_pkg::*;
#(
  parameter int unsigned TICKS = 31
) (
  input  logic SlowClock,
  input  logic Reset,
  input  logic Strobe,
  output logic Phase,
  output logic Wrap
);

  localparam int unsigned   CW   = cnt_width(TICKS);
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  assign Wrap  = Strobe && (cnt_q == LAST);
  assign Phase = phase_q;

  // Next count/phase: advance only on a strobe, wrap and toggle at the end
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (Strobe) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter and phase registers
  always_ff @(posedge SlowClock or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Bicolour LED pattern generator: per-channel mode decode with slow/fast
// blink, fault latches with fast-red override, power gating and a two-phase
// lamp test. LED drives are registered and active-low.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SLOW_TICKS = 31,
  parameter int unsigned FAST_TICKS = 8,
  parameter int unsigned TEST_TICKS = 62
) (
  input  logic                  SlowClock,
  input  logic                  Reset,
  input  logic                  Strobe16ms,
  input  logic                  PwrOn,
  input  logic [3*NUM_CH-1:0]   ChMode,
  input  logic [NUM_CH-1:0]     FaultIn,
  input  logic [NUM_CH-1:0]     FaultClr,
  input  logic                  LampTest,
  output logic [NUM_CH-1:0]     LedG_N,
  output logic [NUM_CH-1:0]     LedR_N,
  output logic [NUM_CH-1:0]     FaultLatched,
  output logic                  TestBusy
);

  localparam int unsigned    TCW   = cnt_width(TEST_TICKS);
  localparam logic [TCW-1:0] TLAST = TCW'(TEST_TICKS - 1);

  // Timebases shared by every channel
  logic slow_phase, slow_wrap, fast_phase, fast_wrap;
  logic slow_phase_d, fast_phase_d;

  led_blink_timebase #(.TICKS(SLOW_TICKS)) u_slow_tb (
    .SlowClock (SlowClock),
    .Reset     (Reset),
    .Strobe    (Strobe16ms),
    .Phase     (slow_phase),
    .Wrap      (slow_wrap)
  );

  led_blink_timebase #(.TICKS(FAST_TICKS)) u_fast_tb (
    .SlowClock (SlowClock),
    .Reset     (Reset),
    .Strobe    (Strobe16ms),
    .Phase     (fast_phase),
    .Wrap      (fast_wrap)
  );

  // LEDs are decoded from next-cycle phase values so a phase change reaches
  // the pins on the same edge that registers it.
  assign slow_phase_d = slow_phase ^ slow_wrap;
  assign fast_phase_d = fast_phase ^ fast_wrap;

  // Fault latches: set wins over clear in the same cycle
  logic [NUM_CH-1:0] fault_q, fault_d;
  assign fault_d      = (fault_q & ~FaultClr) | FaultIn;
  assign FaultLatched = fault_q;

  // Lamp-test sequencer. armed_q stays low after reset until LampTest has
  // been seen low, so a request held through reset cannot retrigger.
  lt_state_e      state_q, state_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           lamp_q;
  logic           armed_q;
  logic           lt_rise;

  assign lt_rise  = LampTest && !lamp_q && armed_q;
  assign TestBusy = (state_q != IDLE);

  // Sequencer next state: each test phase lasts TEST_TICKS strobes and the
  // phase counter restarts at zero on entry to each phase
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (lt_rise) begin
          state_d = TEST_G;
          tcnt_d  = '0;
        end
      end
      TEST_G: begin
        if (Strobe16ms) begin
          if (tcnt_q == TLAST) begin
            state_d = TEST_R;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
      end
      TEST_R: begin
        if (Strobe16ms) begin
          if (tcnt_q == TLAST) begin
            state_d = IDLE;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  // Sequencer, edge detector and fault latch registers
  always_ff @(posedge SlowClock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      lamp_q  <= 1'b0;
      armed_q <= 1'b0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      lamp_q  <= LampTest;
      armed_q <= armed_q | ~LampTest;
      fault_q <= fault_d;
    end
  end

  // Per-channel decode, priority: lamp test, power off, fault, mode
  logic [NUM_CH-1:0] led_g_d, led_r_d;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    led_mode_e  mode;
    led_state_t led;

    assign mode = led_mode_e'(ChMode[3*n +: 3]);

    // Resolve this channel's lamp state for the next cycle
    always_comb begin
      led = LED_OFF;
      if (state_d == TEST_G) begin
        led = LED_GREEN;
      end else if (state_d == TEST_R) begin
        led = LED_RED;
      end else if (!PwrOn) begin
        led = LED_OFF;
      end else if (fault_d[n]) begin
        led = fast_phase_d ? LED_RED : LED_OFF;
      end else begin
        unique case (mode)
          MODE_OFF:    led = LED_OFF;
          MODE_GREEN:  led = LED_GREEN;
          MODE_RED:    led = LED_RED;
          MODE_AMBER:  led = LED_AMBER;
          MODE_SLOW_G: led = slow_phase_d ? LED_GREEN : LED_OFF;
          MODE_SLOW_R: led = slow_phase_d ? LED_RED : LED_OFF;
          MODE_ALT:    led = slow_phase_d ? LED_GREEN : LED_RED;
          MODE_FAST_R: led = fast_phase_d ? LED_RED : LED_OFF;
          default:     led = LED_OFF;
        endcase
      end
    end

    assign led_g_d[n] = led.g;
    assign led_r_d[n] = led.r;
  end

  // Registered active-low LED drives
  logic [NUM_CH-1:0] led_g_n_q, led_r_n_q;

  // Output registers, dark during reset
  always_ff @(posedge SlowClock or posedge Reset) begin
    if (Reset) begin
      led_g_n_q <= '1;
      led_r_n_q <= '1;
    end else begin
      led_g_n_q <= ~led_g_d;
      led_r_n_q <= ~led_r_d;
    end
  end

  assign LedG_N = led_g_n_q;
  assign LedR_N = led_r_n_q;

endmodule
